// File: rtl/compare_seq.sv
// Sequential operand comparator: captures NUM_IN operands, scans one per clock, reports max/min index,
// all-equal and ascending flags. Define COMPARE_SIGNED_EN for two's-complement ordering.
module compare_seq #(
    parameter int WIDTH = 3,
    parameter int NUM_IN = 3,
    localparam int IDX_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        max_idx,
    output logic [IDX_W-1:0]        min_idx,
    output logic                    all_eq,
    output logic                    ascending
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

    state_e                    state_q, state_d;
    logic [NUM_IN*WIDTH-1:0]   ops_q, ops_d;
    logic [WIDTH-1:0]          max_val_q, max_val_d;
    logic [WIDTH-1:0]          min_val_q, min_val_d;
    logic [WIDTH-1:0]          prev_q, prev_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [IDX_W-1:0]          max_idx_q, max_idx_d;
    logic [IDX_W-1:0]          min_idx_q, min_idx_d;
    logic                      all_eq_q, all_eq_d;
    logic                      asc_q, asc_d;
    logic [WIDTH-1:0]          cur;
    logic [WIDTH-1:0]          op0;

    function automatic logic op_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef COMPARE_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    assign op0 = ops_q[WIDTH-1:0];

    always_comb begin
        cur = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (idx_q == k[IDX_W-1:0]) cur = ops_q[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d   = state_q;
        ops_d     = ops_q;
        max_val_d = max_val_q;
        min_val_d = min_val_q;
        prev_d    = prev_q;
        idx_d     = idx_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        all_eq_d  = all_eq_q;
        asc_d     = asc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ops_d     = in_data;
                    max_val_d = in_data[WIDTH-1:0];
                    min_val_d = in_data[WIDTH-1:0];
                    prev_d    = in_data[WIDTH-1:0];
                    max_idx_d = '0;
                    min_idx_d = '0;
                    all_eq_d  = 1'b1;
                    asc_d     = 1'b1;
                    idx_d     = IDX_W'(1);
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                // Strict compares: ties keep the earlier (lower) index
                if (op_lt(max_val_q, cur)) begin
                    max_val_d = cur;
                    max_idx_d = idx_q;
                end
                if (op_lt(cur, min_val_q)) begin
                    min_val_d = cur;
                    min_idx_d = idx_q;
                end
                if (cur != op0) all_eq_d = 1'b0;
                if (op_lt(cur, prev_q)) asc_d = 1'b0;
                prev_d = cur;
                if (idx_q == LAST_IDX) state_d = DONE;
                else                   idx_d = idx_q + IDX_W'(1);
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ops_q     <= '0;
            max_val_q <= '0;
            min_val_q <= '0;
            prev_q    <= '0;
            idx_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
            all_eq_q  <= 1'b0;
            asc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ops_q     <= ops_d;
            max_val_q <= max_val_d;
            min_val_q <= min_val_d;
            prev_q    <= prev_d;
            idx_q     <= idx_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
            all_eq_q  <= all_eq_d;
            asc_q     <= asc_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign max_idx   = max_idx_q;
    assign min_idx   = min_idx_q;
    assign all_eq    = all_eq_q;
    assign ascending = asc_q;

endmodule
